// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and full-adder helper for the dual adder checker
package adder_pkg;

  localparam int CLA_GROUP = 4;

  // Returns {carry, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit carry-lookahead group with group generate/propagate
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g_out,
  output logic       p_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of g, p and cin; nothing ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_out = &p;

  assign sum = p ^ c;

endmodule

// File: rtl/dual_adder_checker.sv
// rtl/dual_adder_checker.sv - registered CLA and ripple adders on shared operands with a mismatch flag
module dual_adder_checker
  import adder_pkg::*;
#(
  parameter int WIDTH = 4  // positive multiple of CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_cla,
  output logic             cout_cla,
  output logic [WIDTH-1:0] out_rc,
  output logic             cout_rc,
  output logic             mismatch
);

  localparam int NGRP = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] sum_cla;
  logic [NGRP:0]    grp_c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;

  logic [WIDTH-1:0] sum_rc;
  logic [WIDTH:0]   rc_c;

  logic             mismatch_d;

  assign grp_c[0] = cin;

  for (genvar k = 0; k < NGRP; k++) begin : g_cla
    cla_group4 u_grp (
      .a     (in1[k*CLA_GROUP +: CLA_GROUP]),
      .b     (in2[k*CLA_GROUP +: CLA_GROUP]),
      .cin   (grp_c[k]),
      .sum   (sum_cla[k*CLA_GROUP +: CLA_GROUP]),
      .g_out (grp_g[k]),
      .p_out (grp_p[k])
    );
    assign grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
  end

  assign rc_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rc
    assign {rc_c[i+1], sum_rc[i]} = full_add(in1[i], in2[i], rc_c[i]);
  end

  assign mismatch_d = {grp_c[NGRP], sum_cla} != {rc_c[WIDTH], sum_rc};

  // Results and mismatch only update on valid input; out_valid tracks in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cla   <= '0;
      cout_cla  <= 1'b0;
      out_rc    <= '0;
      cout_rc   <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_cla  <= sum_cla;
        cout_cla <= grp_c[NGRP];
        out_rc   <= sum_rc;
        cout_rc  <= rc_c[WIDTH];
        mismatch <= mismatch_d;
      end
    end
  end

endmodule

// File: tb/tb_dual_adder_checker.sv
// tb/tb_dual_adder_checker.sv - self-checking bench for dual_adder_checker at widths 4, 8 and 16
module tb_dual_adder_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        v4 = 1'b0, c4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ov4, cc4, cr4, mm4;
  logic [3:0]  oc4, or4;

  logic        v8 = 1'b0, c8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ov8, cc8, cr8, mm8;
  logic [7:0]  oc8, or8;

  logic        v16 = 1'b0, c16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ov16, cc16, cr16, mm16;
  logic [15:0] oc16, or16;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dual_adder_checker #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in1(a4), .in2(b4), .cin(c4),
    .out_valid(ov4), .out_cla(oc4), .cout_cla(cc4), .out_rc(or4), .cout_rc(cr4), .mismatch(mm4)
  );

  dual_adder_checker #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in1(a8), .in2(b8), .cin(c8),
    .out_valid(ov8), .out_cla(oc8), .cout_cla(cc8), .out_rc(or8), .cout_rc(cr8), .mismatch(mm8)
  );

  dual_adder_checker #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in1(a16), .in2(b16), .cin(c16),
    .out_valid(ov16), .out_cla(oc16), .cout_cla(cc16), .out_rc(or16), .cout_rc(cr16), .mismatch(mm16)
  );

  // Reference: the full-width integer sum of whatever was last accepted.
  logic        e4v = 1'b0, e8v = 1'b0, e16v = 1'b0;
  logic [4:0]  e4 = '0;
  logic [8:0]  e8 = '0;
  logic [16:0] e16 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e4v <= 1'b0; e8v <= 1'b0; e16v <= 1'b0;
      e4 <= '0; e8 <= '0; e16 <= '0;
    end else begin
      e4v <= v4; e8v <= v8; e16v <= v16;
      if (v4)  e4  <= {1'b0, a4}  + {1'b0, b4}  + {4'd0, c4};
      if (v8)  e8  <= {1'b0, a8}  + {1'b0, b8}  + {8'd0, c8};
      if (v16) e16 <= {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
  endtask

  // Packed as {valid, cout_cla, out_cla, cout_rc, out_rc, mismatch}.
  always @(negedge clk) begin
    check("cycle_w4",  {52'd0, ov4, cc4, oc4, cr4, or4, mm4},
                       {52'd0, e4v, e4[4], e4[3:0], e4[4], e4[3:0], 1'b0});
    check("cycle_w8",  {44'd0, ov8, cc8, oc8, cr8, or8, mm8},
                       {44'd0, e8v, e8[8], e8[7:0], e8[8], e8[7:0], 1'b0});
    check("cycle_w16", {28'd0, ov16, cc16, oc16, cr16, or16, mm16},
                       {28'd0, e16v, e16[16], e16[15:0], e16[16], e16[15:0], 1'b0});
  end

  task automatic lit4(input string name, input logic v, input logic co, input logic [3:0] s);
    check(name, {52'd0, ov4, cc4, oc4, cr4, or4, mm4}, {52'd0, v, co, s, co, s, 1'b0});
  endtask

  // Apply one vector to dut4 (others get random operands with the same valid) for one cycle.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk); #1;
    v4 = v; a4 = a; b4 = b; c4 = ci;
    v8 = v; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    v16 = v; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      v4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
    end
    @(posedge clk); #1;
    lit4("reset_hold", 1'b0, 1'b0, 4'b0000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    v4 = 1'b0; v8 = 1'b0; v16 = 1'b0;

    step(1'b1, 4'b0010, 4'b1110, 1'b0); lit4("wrap_0010_1110", 1'b1, 1'b1, 4'b0000);
    step(1'b1, 4'b0010, 4'b1010, 1'b0); lit4("seq_0010_1010",  1'b1, 1'b0, 4'b1100);
    step(1'b1, 4'b0010, 4'b0111, 1'b0); lit4("seq_0010_0111",  1'b1, 1'b0, 4'b1001);
    step(1'b1, 4'b0110, 4'b0110, 1'b0); lit4("seq_0110_0110",  1'b1, 1'b0, 4'b1100);
    step(1'b1, 4'b1111, 4'b0000, 1'b1); lit4("prop_1111_0000", 1'b1, 1'b1, 4'b0000);
    step(1'b1, 4'b1111, 4'b1111, 1'b1); lit4("max_1111_1111",  1'b1, 1'b1, 4'b1111);
    step(1'b1, 4'b0000, 4'b0000, 1'b0); lit4("zero_0000_0000", 1'b1, 1'b0, 4'b0000);

    step(1'b1, 4'b0110, 4'b0110, 1'b0); lit4("hold_load", 1'b1, 1'b0, 4'b1100);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      lit4("hold_idle", 1'b0, 1'b0, 4'b1100);
    end

    // Asynchronous reset between clock edges.
    step(1'b1, 4'b1001, 4'b0011, 1'b1); lit4("pre_reset", 1'b1, 1'b0, 4'b1101);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    lit4("async_reset", 1'b0, 1'b0, 4'b0000);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, 4'b0101, 4'b0110, 1'b1); lit4("post_reset", 1'b1, 1'b0, 4'b1100);

    // Exhaustive WIDTH=4 sweep; wider instances see random operands alongside.
    for (int n = 0; n < 512; n++) begin
      logic [8:0] idx;
      idx = 9'(n);
      step(1'b1, idx[3:0], idx[7:4], idx[8]);
    end

    // Random valid gaps across all widths.
    for (int n = 0; n < 64; n++)
      step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));

    step(1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dual_adder_checker.md
Name: dual_adder_checker

Overview:
- Registered arithmetic block containing two independent unsigned adders on the same operands: a carry-lookahead adder (CLA) and a ripple-carry adder (RC).
- Both results are registered and compared every cycle. A mismatch flag exposes any disagreement.
- Used as a datapath adder with built-in self-consistency checking. Default operand width 4 bits.

Parameters:
- WIDTH, 4, operand/sum width in bits; must be a positive multiple of 4 (CLA group size).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- in1  input  WIDTH  operand A, unsigned
- in2  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  registered results valid
- out_cla  output  WIDTH  CLA sum, registered
- cout_cla  output  1  CLA carry-out, registered
- out_rc  output  WIDTH  RC sum, registered
- cout_rc  output  1  RC carry-out, registered
- mismatch  output  1  {cout_cla,out_cla} != {cout_rc,out_rc}, registered with the results

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert is the system's job): all outputs 0 (out_valid=0, sums=0, couts=0, mismatch=0).
- Arithmetic (both paths): {cout, out} = in1 + in2 + cin, full WIDTH+1 result, no saturation. Wrap-around is carried entirely in cout.
- RC path:
  - Chain of WIDTH full adders.
  - s_i = a_i ^ b_i ^ c_i.
  - c_{i+1} = a_i&b_i | c_i&(a_i^b_i).
  - c_0 = cin.
- CLA path:
  - Per bit: g_i = a_i&b_i, p_i = a_i^b_i.
  - Within each 4-bit group, carries are computed directly from g, p and group carry-in via two-level sum-of-products. No internal rippling.
  - Each group produces group generate G and propagate P.
  - Carries between groups: c_{k+1} = G_k | P_k&c_k.
  - s_i = p_i ^ c_i.
- Both adders are purely combinational. Results are captured on the rising clk edge when in_valid=1.
- Latency: exactly 1 cycle. out_valid = in_valid delayed one cycle.
- When in_valid=0: sum/cout/mismatch registers hold their previous values and out_valid goes 0 next cycle.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- mismatch is computed from the same-cycle combinational results and registered alongside them. It is never set while out_valid=0 after reset.
- Reset asserted mid-operation clears all outputs immediately. The first valid capture after release behaves normally.
- X-free: all outputs are defined after reset regardless of input state.

Decomposition:
- Shared package (adder_pkg):
  - constant CLA_GROUP = 4
  - function for full-adder sum/carry
- Sub-module cla_group4:
  - Inputs: 4-bit a, 4-bit b, cin.
  - Outputs: 4-bit sum, group G, group P.
  - Instantiated WIDTH/4 times by generate.
- RC chain: generate loop inside the top module.
- Top module: owns both datapaths, the comparator and the output registers.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, out_valid=0. Asserting reset mid-stream clears outputs without waiting for a clock.
- in1=0010, in2=1110, cin=0, valid -> next cycle out_cla=out_rc=0000, cout_cla=cout_rc=1, mismatch=0, out_valid=1.
- Directed sequence, one per cycle, cin=0:
  - 0010+1010 -> 1100, cout 0
  - 0010+0111 -> 1001, cout 0
  - 0110+0110 -> 1100, cout 0
  - Check 1-cycle latency and that both paths agree.
- Carry extremes:
  - 1111+0000, cin=1 -> 0000, cout 1 (full propagate across groups)
  - 1111+1111, cin=1 -> 1111, cout 1
  - 0000+0000, cin=0 -> 0000, cout 0
- Hold behaviour: drop in_valid for 3 cycles after a valid 0110+0110 -> out_valid=0, outputs stay 1100/0.
- Exhaustive for WIDTH=4: all 512 combinations of in1, in2 and cin -> both paths equal the reference sum, mismatch never 1. Repeat a random subset with WIDTH=8 and WIDTH=16.
